// File: rtl/core_step_checker.sv
// Stepping and self-check controller for the single-cycle RV32 core.
// Gates the core step enable and compares probe channels against a programmable expectation table.
module core_step_checker #(
    parameter int DATA_W = 32,
    parameter int CHAN   = 4,
    parameter int DEPTH  = 16,
    parameter int STEP_W = 16,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CH_W  = (CHAN > 1) ? $clog2(CHAN) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [CH_W-1:0]        cfg_chan,
    input  logic [DATA_W-1:0]      cfg_expect,
    input  logic [DATA_W-1:0]      cfg_mask,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   stop_on_fail,
    input  logic [STEP_W-1:0]      steps,
    input  logic                   abort,
    input  logic [CHAN*DATA_W-1:0] probe_data,
    output logic                   step_en,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic [IDX_W-1:0]       fail_idx,
    output logic [DATA_W-1:0]      fail_value,
    output logic [STEP_W-1:0]      step_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [STEP_W-1:0]   r_steps;
    logic [STEP_W-1:0]   r_count;
    logic [STEP_W-1:0]   w_cnt_inc;
    logic [IDX_W-1:0]    r_entry;
    logic                r_pass;
    logic                r_fail;
    logic [IDX_W-1:0]    r_fail_idx;
    logic [DATA_W-1:0]   r_fail_value;
    logic                w_start;
    logic                w_step_en;
    logic                w_mismatch;
    logic [DATA_W-1:0]   w_probe;

    logic [DEPTH-1:0]    r_valid;
    logic [CH_W-1:0]     r_tab_chan [DEPTH];
    logic [DATA_W-1:0]   r_tab_exp  [DEPTH];
    logic [DATA_W-1:0]   r_tab_mask [DEPTH];

    // Only the valid bits are reset; entry payloads are meaningless until written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (cfg_we) begin
            r_valid[cfg_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_tab_chan[cfg_idx] <= cfg_chan;
            r_tab_exp[cfg_idx]  <= cfg_expect;
            r_tab_mask[cfg_idx] <= cfg_mask;
        end
    end

    always_comb begin
        w_probe = '0;
        for (int unsigned k = 0; k < CHAN; k++) begin
            if (r_tab_chan[r_entry] == CH_W'(k)) begin
                w_probe = probe_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_mismatch = (r_state == S_CHECK) && r_valid[r_entry] &&
                        (((w_probe ^ r_tab_exp[r_entry]) & r_tab_mask[r_entry]) != '0);
    assign w_cnt_inc  = (r_count == '1) ? r_count : r_count + 1'b1;
    assign w_start    = (r_state == S_IDLE) && start && !abort;

    always_comb begin
        w_next    = r_state;
        w_step_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (steps == '0) w_next = S_DONE;
                    else             w_next = mode ? S_STEP : S_RUN;
                end
            end
            S_RUN: begin
                w_step_en = 1'b1;
                if (w_cnt_inc == r_steps) w_next = S_DONE;
            end
            S_STEP: begin
                w_step_en = 1'b1;
                w_next    = S_SETTLE;
            end
            S_SETTLE: w_next = S_CHECK;
            S_CHECK: begin
                if ((w_mismatch && stop_on_fail) || (r_count == r_steps)) w_next = S_DONE;
                else                                                      w_next = S_STEP;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort gates the core enable combinationally so no instruction retires this cycle.
        if (abort) begin
            w_next    = S_IDLE;
            w_step_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_steps      <= '0;
            r_count      <= '0;
            r_entry      <= '0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_value <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_steps      <= steps;
                r_count      <= '0;
                r_entry      <= '0;
                r_pass       <= (steps == '0);
                r_fail       <= 1'b0;
                r_fail_idx   <= '0;
                r_fail_value <= '0;
            end else if (abort) begin
                if (r_state != S_IDLE) r_pass <= 1'b0;
            end else begin
                if (w_step_en) r_count <= w_cnt_inc;
                if (r_state == S_CHECK) begin
                    r_entry <= (r_entry == IDX_W'(DEPTH - 1)) ? '0 : r_entry + 1'b1;
                    if (w_mismatch && !r_fail) begin
                        r_fail       <= 1'b1;
                        r_fail_idx   <= r_entry;
                        r_fail_value <= w_probe;
                    end
                end
                if ((w_next == S_DONE) && (r_state != S_DONE)) begin
                    r_pass <= ~(r_fail | w_mismatch);
                end
            end
        end
    end

    assign step_en    = w_step_en;
    assign busy       = (r_state == S_RUN) || (r_state == S_STEP) ||
                        (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done       = (r_state == S_DONE) && !abort;
    assign pass       = r_pass;
    assign fail       = r_fail;
    assign fail_idx   = r_fail_idx;
    assign fail_value = r_fail_value;
    assign step_count = r_count;

endmodule

// File: tb/tb_core_step_checker.sv
// Scoreboard bench for core_step_checker: a fake core retires on step_en and exposes
// step-indexed probe values; a behavioural model predicts each run's outcome.
module tb_core_step_checker;

    localparam int DW = 32;
    localparam int CH = 4;
    localparam int DP = 4;
    localparam int SW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_idx = '0;
    logic [1:0]        cfg_chan = '0;
    logic [DW-1:0]     cfg_expect = '0;
    logic [DW-1:0]     cfg_mask = '0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic              stop_on_fail = 1'b0;
    logic [SW-1:0]     steps = '0;
    logic              abort = 1'b0;
    logic [CH*DW-1:0]  probe_data;
    logic              step_en, busy, done, pass, fail;
    logic [1:0]        fail_idx;
    logic [DW-1:0]     fail_value;
    logic [SW-1:0]     step_count;

    core_step_checker #(.DATA_W(DW), .CHAN(CH), .DEPTH(DP), .STEP_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_chan(cfg_chan),
        .cfg_expect(cfg_expect), .cfg_mask(cfg_mask), .start(start), .mode(mode),
        .stop_on_fail(stop_on_fail), .steps(steps), .abort(abort), .probe_data(probe_data),
        .step_en(step_en), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_idx(fail_idx), .fail_value(fail_value), .step_count(step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pass;
        bit          fail;
        int          fidx;
        logic [31:0] fval;
        int          cnt;
        int          en_base;
    } exp_t;

    exp_t        sb[$];
    int          en_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          retired = 0;
    int          run_base = 0;
    int          en_cnt = 0;
    int          cyc = 0;
    bit          m_valid [DP];
    int          m_chan  [DP];
    logic [31:0] m_exp   [DP];
    logic [31:0] m_mask  [DP];

    // Observable core state after the i-th instruction of the current run.
    function automatic logic [31:0] probe_fn(input int i, input int k);
        case (k)
            0:       return 32'h1234_FFFF ^ (32'(i) << 16);
            1:       return 32'(i);
            2:       return 32'(i + 1);
            default: return 32'(i * 7);
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < CH; k++) probe_data[k*DW +: DW] = probe_fn(retired - run_base, k);
    end

    always @(posedge clk) begin
        if (step_en === 1'b1) begin
            retired <= retired + 1;
            en_cnt  <= en_cnt + 1;
            en_q.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    function automatic exp_t model(input int n, input bit md, input bit stop);
        exp_t r;
        r.pass = 1'b1; r.fail = 1'b0; r.fidx = 0; r.fval = '0; r.cnt = n; r.en_base = 0;
        if (md) begin
            for (int i = 1; i <= n; i++) begin
                int e;
                logic [31:0] obs;
                e   = (i - 1) % DP;
                obs = probe_fn(i, m_chan[e]);
                if (m_valid[e] && (((obs ^ m_exp[e]) & m_mask[e]) != 0)) begin
                    if (!r.fail) begin
                        r.fail = 1'b1; r.fidx = e; r.fval = obs;
                    end
                    if (stop) begin
                        r.cnt = i;
                        break;
                    end
                end
            end
        end
        r.pass = !r.fail;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pass",       64'(pass),                 64'(e.pass));
                chk("fail",       64'(fail),                 64'(e.fail));
                chk("fail_idx",   64'(fail_idx),             64'(e.fidx));
                chk("fail_value", 64'(fail_value),           64'(e.fval));
                chk("step_count", 64'(step_count),           64'(e.cnt));
                chk("en_cycles",  64'(en_cnt - e.en_base),   64'(e.cnt));
                chk("busy_at_done", 64'(busy),               64'd0);
            end
        end
    end

    task automatic cfg_write(input int idx, input int ch, input logic [31:0] ex, input logic [31:0] mk);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_chan = 2'(ch); cfg_expect = ex; cfg_mask = mk;
        @(negedge clk);
        cfg_we = 1'b0;
        m_valid[idx] = 1'b1; m_chan[idx] = ch; m_exp[idx] = ex; m_mask[idx] = mk;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic do_run(input int n, input bit md, input bit stop, output int s);
        exp_t e;
        @(negedge clk);
        run_base = retired;
        e = model(n, md, stop);
        e.en_base = en_cnt;
        sb.push_back(e);
        en_q.delete();
        s = cyc;
        steps = SW'(n); mode = md; stop_on_fail = stop; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3 * n + 10);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int k;
        for (int i = 0; i < DP; i++) m_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {step_en, busy, done, pass, fail, fail_idx, fail_value, step_count}, 64'd0);
        rst_n = 1'b1;

        // Reset during SETTLE of step 2
        @(negedge clk);
        run_base = retired;
        steps = 5; mode = 1'b1; stop_on_fail = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(step_count == 2 && step_en == 1'b0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reset_at_settle", 64'(step_count), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {step_en, busy, done, pass, fail, fail_idx, fail_value, step_count}, 64'd0);
        for (int i = 0; i < DP; i++) m_valid[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_run(12, 1'b0, 1'b0, s);
        chk("run12_count", 64'(en_q.size()), 64'd12);
        if (en_q.size() == 12) begin
            chk("run12_first", 64'(en_q[0]), 64'(s + 1));
            chk("run12_contig", 64'(en_q[11] - en_q[0]), 64'd11);
        end

        cfg_write(0, 1, 32'h1, 32'hFFFF_FFFF);
        cfg_write(1, 2, 32'h3, 32'hFFFF_FFFF);
        cfg_write(2, 0, 32'hFFFF_FFFF, 32'h0000_FFFF);
        do_run(3, 1'b1, 1'b0, s);
        chk("chk_en_n", 64'(en_q.size()), 64'd3);
        if (en_q.size() == 3) begin
            chk("chk_en_c1", 64'(en_q[0]), 64'(s + 1));
            chk("chk_en_c4", 64'(en_q[1]), 64'(s + 4));
            chk("chk_en_c7", 64'(en_q[2]), 64'(s + 7));
        end

        cfg_write(1, 1, 32'h3, 32'hFFFF_FFFF);
        do_run(3, 1'b1, 1'b1, s);
        chk("stop_fail_idx", 64'(fail_idx), 64'd1);
        chk("stop_fail_value", 64'(fail_value), 64'd2);

        cfg_write(0, 0, 32'h0, 32'h0);
        cfg_write(1, 3, 32'h0, 32'hFFFF_FFFF);
        cfg_write(2, 0, 32'h0, 32'h0);
        cfg_write(3, 0, 32'h0, 32'h0);
        do_run(6, 1'b1, 1'b0, s);
        chk("wrap_fail_value", 64'(fail_value), 64'd14);
        chk("wrap_count", 64'(step_count), 64'd6);

        do_run(0, 1'b1, 1'b0, s);
        chk("zero_pass", 64'(pass), 64'd1);

        // Abort during a long RUN
        @(negedge clk);
        run_base = retired;
        steps = 100; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (step_count != 40 && k < 120) begin
            @(negedge clk);
            k++;
        end
        abort = 1'b1;
        #1;
        chk("abort_step_en", 64'(step_en), 64'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(step_count), 64'd40);
        chk("abort_pass", 64'(pass), 64'd0);
        repeat (3) @(negedge clk);

        // Abort wins over start in IDLE
        @(negedge clk);
        steps = 3; mode = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'd0);
        chk("abort_start_en", 64'(step_en), 64'd0);

        for (int r = 0; r < 25; r++) begin
            for (int e = 0; e < DP; e++) begin
                logic [31:0] mk;
                case ($urandom_range(0, 2))
                    0:       mk = 32'h0;
                    1:       mk = 32'hF;
                    default: mk = 32'hFFFF_FFFF;
                endcase
                cfg_write(e, $urandom_range(0, 3), 32'($urandom_range(0, 9)), mk);
            end
            do_run($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
